// File: rtl/tick_scheduler.sv
// Multi-channel software-timer scheduler: NCH tick-driven down-counters feeding a valid/ack event port.
// Build option TICK_SCHED_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module tick_scheduler #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_periodic,
    input  logic              start,
    input  logic              stop,
    output logic              irq_valid,
    output logic [CH_W-1:0]   irq_ch,
    input  logic              irq_ack,
    output logic [NCH-1:0]    active,
    output logic [NCH-1:0]    overrun
);

    // Event handshake: irq_valid/irq_ch stay stable until the cycle irq_ack is high
    // (event consumed) or the presented channel is stopped (event withdrawn).
    typedef enum logic {IDLE, PRESENT} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   irq_ch_q, irq_ch_d;
    logic [CNT_W-1:0]  period_q [NCH];
    logic [CNT_W-1:0]  period_d [NCH];
    logic [CNT_W-1:0]  cnt_q [NCH];
    logic [CNT_W-1:0]  cnt_d [NCH];
    logic [NCH-1:0]    periodic_q, periodic_d;
    logic [NCH-1:0]    active_q, active_d;
    logic [NCH-1:0]    pending_q, pending_d;
    logic [NCH-1:0]    overrun_q, overrun_d;
    logic [NCH-1:0]    sel, ack_clr, expire, eligible;
    logic              grant_found;
    logic [CH_W-1:0]   grant_ch;
`ifdef TICK_SCHED_RR_EN
    logic [CH_W-1:0]   last_q, last_d;
`endif

    always_comb begin
        sel     = '0;
        ack_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i]     = (cfg_ch == CH_W'(i));
            ack_clr[i] = (state_q == PRESENT) && irq_ack && (irq_ch_q == CH_W'(i));
        end
    end

    // Per-channel update: stop beats start, start beats tick; cfg_we lands after the start load.
    always_comb begin
        periodic_d = periodic_q;
        active_d   = active_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        expire     = '0;
        for (int i = 0; i < NCH; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            if (stop && sel[i]) begin
                active_d[i]  = 1'b0;
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end else begin
                if (start && sel[i] && (period_q[i] != '0)) begin
                    cnt_d[i]    = period_q[i];
                    active_d[i] = 1'b1;
                end else if (tick && active_q[i]) begin
                    if (cnt_q[i] == CNT_W'(1)) begin
                        expire[i] = 1'b1;
                        if (periodic_q[i]) begin
                            cnt_d[i] = period_q[i];
                        end else begin
                            active_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                if (expire[i]) begin
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !ack_clr[i]) begin
                        overrun_d[i] = 1'b1;
                    end
                end else if (ack_clr[i]) begin
                    pending_d[i] = 1'b0;
                end
            end
            if (cfg_we && sel[i]) begin
                period_d[i]   = cfg_period;
                periodic_d[i] = cfg_periodic;
            end
        end
    end

    // A channel being stopped this cycle is not eligible, so no stale event is presented.
    always_comb begin
        eligible    = pending_q & ~(stop ? sel : '0);
        grant_found = 1'b0;
        grant_ch    = '0;
`ifdef TICK_SCHED_RR_EN
        for (int k = 0; k < NCH; k++) begin
            if (!grant_found && eligible[(int'(last_q) + 1 + k) % NCH]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'((int'(last_q) + 1 + k) % NCH);
            end
        end
`else
        for (int k = NCH - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(k);
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        irq_ch_d = irq_ch_q;
`ifdef TICK_SCHED_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d  = PRESENT;
                    irq_ch_d = grant_ch;
`ifdef TICK_SCHED_RR_EN
                    last_d   = grant_ch;
`endif
                end
            end
            PRESENT: begin
                if (irq_ack || (stop && (cfg_ch == irq_ch_q))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            irq_ch_q   <= '0;
            periodic_q <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
`ifdef TICK_SCHED_RR_EN
            last_q     <= CH_W'(NCH - 1);
`endif
        end else begin
            state_q    <= state_d;
            irq_ch_q   <= irq_ch_d;
            periodic_q <= periodic_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
`ifdef TICK_SCHED_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign irq_valid = (state_q == PRESENT);
    assign irq_ch    = irq_ch_q;
    assign active    = active_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural channel/event model.
module tb_tick_scheduler;
    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             cfg_periodic = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             irq_ack = 1'b0;
    logic             irq_valid;
    logic [CH_W-1:0]  irq_ch;
    logic [NCH-1:0]   active;
    logic [NCH-1:0]   overrun;

    tick_scheduler #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_periodic(cfg_periodic), .start(start), .stop(stop),
        .irq_valid(irq_valid), .irq_ch(irq_ch), .irq_ack(irq_ack),
        .active(active), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             m_period [NCH];
    int             m_cnt [NCH];
    logic [NCH-1:0] m_periodic = '0, m_active = '0, m_pending = '0, m_overrun = '0;
    bit             m_present = 1'b0;
    int             m_ch = 0;
    int             m_last = NCH - 1;

    task automatic model_step();
        logic [NCH-1:0] old_pend, elig;
        bit ack_hit, pres_stop, exp_now, found;
        int g;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_period[c] = 0;
                m_cnt[c]    = 0;
            end
            m_periodic = '0; m_active = '0; m_pending = '0; m_overrun = '0;
            m_present = 1'b0; m_ch = 0; m_last = NCH - 1;
            return;
        end
        old_pend  = m_pending;
        ack_hit   = m_present && irq_ack;
        pres_stop = m_present && stop && (int'(cfg_ch) == m_ch);
        for (int c = 0; c < NCH; c++) begin
            bit hit, acked;
            hit     = (int'(cfg_ch) == c);
            acked   = ack_hit && (m_ch == c);
            exp_now = 1'b0;
            if (stop && hit) begin
                m_active[c] = 1'b0; m_pending[c] = 1'b0; m_overrun[c] = 1'b0;
            end else begin
                if (start && hit && m_period[c] != 0) begin
                    m_cnt[c] = m_period[c];
                    m_active[c] = 1'b1;
                end else if (tick && m_active[c]) begin
                    if (m_cnt[c] == 1) begin
                        exp_now = 1'b1;
                        if (m_periodic[c]) m_cnt[c] = m_period[c];
                        else m_active[c] = 1'b0;
                    end else begin
                        m_cnt[c] = (m_cnt[c] - 1) & ((1 << CNT_W) - 1);
                    end
                end
                if (exp_now) begin
                    if (m_pending[c] && !acked) m_overrun[c] = 1'b1;
                    m_pending[c] = 1'b1;
                end else if (acked) begin
                    m_pending[c] = 1'b0;
                end
            end
            if (cfg_we && hit) begin
                m_period[c]   = int'(cfg_period);
                m_periodic[c] = cfg_periodic;
            end
        end
        if (m_present) begin
            if (ack_hit || pres_stop) m_present = 1'b0;
        end else begin
            elig = old_pend;
            if (stop) elig[cfg_ch] = 1'b0;
            found = 1'b0;
            g = 0;
`ifdef TICK_SCHED_RR_EN
            for (int k = 0; k < NCH; k++) begin
                if (!found && elig[(m_last + 1 + k) % NCH]) begin
                    found = 1'b1;
                    g = (m_last + 1 + k) % NCH;
                end
            end
`else
            for (int k = 0; k < NCH; k++) begin
                if (!found && elig[k]) begin
                    found = 1'b1;
                    g = k;
                end
            end
`endif
            if (found) begin
                m_present = 1'b1; m_ch = g; m_last = g;
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("irq_valid", 32'(irq_valid), 32'(m_present));
            if (m_present) check("irq_ch", 32'(irq_ch), 32'(m_ch));
            check("active", 32'(active), 32'(m_active));
            check("overrun", 32'(overrun), 32'(m_overrun));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        tick = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0; reset = 1'b0;
    endtask

    task automatic do_cfg(input int ch, input int period, input bit periodic);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CNT_W'(period); cfg_periodic = periodic;
        step();
    endtask

    task automatic do_start(input int ch);
        start = 1'b1; cfg_ch = CH_W'(ch);
        step();
    endtask

    task automatic do_stop(input int ch);
        stop = 1'b1; cfg_ch = CH_W'(ch);
        step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        step();
    endtask

    int ev;
    int first_ch, second_ch;

    initial begin
        // Reset state
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        reset = 1'b1;
        step();
        check("rst_irq_valid", 32'(irq_valid), 32'd0);
        check("rst_irq_ch", 32'(irq_ch), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // One-shot period 3
        do_cfg(0, 3, 1'b0);
        do_start(0);
        check("oneshot_active", 32'(active[0]), 32'd1);
        do_tick(); do_tick(); do_tick();
        check("oneshot_no_valid_yet", 32'(irq_valid), 32'd0);
        check("oneshot_inactive", 32'(active[0]), 32'd0);
        step();
        check("oneshot_valid", 32'(irq_valid), 32'd1);
        check("oneshot_ch", 32'(irq_ch), 32'd0);
        do_ack();
        check("oneshot_ack_drop", 32'(irq_valid), 32'd0);

        // Periodic period 2 over 6 ticks, acking each event
        do_cfg(1, 2, 1'b1);
        do_start(1);
        ev = 0;
        for (int t = 0; t < 6; t++) begin
            do_tick();
            for (int w = 0; w < 4; w++) begin
                if (irq_valid) begin
                    if (irq_ch == CH_W'(1)) ev++;
                    do_ack();
                    break;
                end
                step();
            end
        end
        check("periodic_events", 32'(ev), 32'd3);
        check("periodic_active", 32'(active[1]), 32'd1);
        check("periodic_no_overrun", 32'(overrun[1]), 32'd0);
        do_stop(1);

        // Overrun on period 1 without ack, then stop withdraws the event
        do_cfg(2, 1, 1'b1);
        do_start(2);
        do_tick();
        do_tick();
        check("overrun_set", 32'(overrun[2]), 32'd1);
        check("overrun_valid", 32'(irq_valid), 32'd1);
        check("overrun_ch", 32'(irq_ch), 32'd2);
        do_stop(2);
        check("stop_withdraw", 32'(irq_valid), 32'd0);
        check("stop_clr_overrun", 32'(overrun[2]), 32'd0);
        check("stop_inactive", 32'(active[2]), 32'd0);
        step();
        check("stop_no_repost", 32'(irq_valid), 32'd0);

        // Channels 0 and 3 expire on the same tick
`ifdef TICK_SCHED_RR_EN
        first_ch = 3; second_ch = 0;
`else
        first_ch = 0; second_ch = 3;
`endif
        do_cfg(0, 1, 1'b0);
        do_cfg(3, 1, 1'b0);
        do_start(0);
        do_start(3);
        do_tick();
        step();
        check("arb_first_ch", 32'(irq_ch), 32'(first_ch));
        do_ack();
        check("arb_gap", 32'(irq_valid), 32'd0);
        step();
        check("arb_second_valid", 32'(irq_valid), 32'd1);
        check("arb_second_ch", 32'(irq_ch), 32'(second_ch));
        do_ack();

        // Channels 0 and 1 pending, previous grant was 0
`ifdef TICK_SCHED_RR_EN
        first_ch = 1; second_ch = 0;
`else
        first_ch = 0; second_ch = 1;
`endif
        do_cfg(1, 1, 1'b0);
        do_start(0);
        do_start(1);
        do_tick();
        step();
        check("arb2_first_ch", 32'(irq_ch), 32'(first_ch));
        do_ack();
        step();
        check("arb2_second_ch", 32'(irq_ch), 32'(second_ch));
        do_ack();

        // Start in the same cycle as a tick: no decrement
        do_cfg(0, 2, 1'b0);
        start = 1'b1; cfg_ch = CH_W'(0); tick = 1'b1;
        step();
        do_tick();
        step();
        check("start_beats_tick", 32'(irq_valid), 32'd0);
        do_tick();
        step();
        check("start_tick_expiry", 32'(irq_valid), 32'd1);
        check("start_tick_ch", 32'(irq_ch), 32'd0);
        do_ack();

        // Stop in the same cycle as the expiring tick
        do_start(0);
        do_tick();
        stop = 1'b1; cfg_ch = CH_W'(0); tick = 1'b1;
        step();
        step();
        step();
        check("stop_beats_tick_valid", 32'(irq_valid), 32'd0);
        check("stop_beats_tick_active", 32'(active[0]), 32'd0);

        // Start with stored period 0 is ignored
        do_cfg(2, 0, 1'b0);
        do_start(2);
        check("zero_period_start", 32'(active[2]), 32'd0);

        // Reset while an event is presented
        do_cfg(1, 1, 1'b1);
        do_start(1);
        do_tick();
        step();
        check("pre_reset_valid", 32'(irq_valid), 32'd1);
        reset = 1'b1;
        step();
        check("mid_reset_valid", 32'(irq_valid), 32'd0);
        check("mid_reset_ch", 32'(irq_ch), 32'd0);
        check("mid_reset_active", 32'(active), 32'd0);
        check("mid_reset_overrun", 32'(overrun), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            tick = ($urandom_range(0, 2) == 0);
            cfg_ch = CH_W'($urandom_range(0, NCH - 1));
            cfg_period = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
            cfg_periodic = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            cfg_we = (r <= 1) || (r == 5);
            start  = (r == 2) || (r == 3) || (r == 5);
            stop   = (r == 4);
            irq_ack = 1'($urandom_range(0, 1));
            if (n % 1000 == 999) reset = 1'b1;
            step();
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
